// File: rtl/i2c_mpu_target.sv
// I2C target emulating the MPU-6050 register subset used by our master.
// Both bus lines are oversampled on clk; SDA is driven open-drain through sda_oe.
module i2c_mpu_target #(
    parameter logic [6:0] SLAVE_ADDRESS  = 7'h69,
    parameter logic [7:0] WHO_AM_I_VALUE = 8'h68
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic        sample_valid,
    input  logic [15:0] temp_in,
    input  logic [15:0] gyro_x_in,
    input  logic [15:0] gyro_y_in,
    input  logic [15:0] gyro_z_in,
    output logic [7:0]  self_test_x,
    output logic [7:0]  self_test_y,
    output logic [7:0]  self_test_z,
    output logic        busy,
    output logic        wr_strobe
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_MACK, S_WAIT_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic        scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, tx_q, tx_d, ptr_q, ptr_d;
    logic        rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
    logic [7:0]  st_x_q, st_x_d, st_y_q, st_y_d, st_z_q, st_z_d;
    logic [15:0] temp_q, temp_d, gx_q, gx_d, gy_q, gy_d, gz_q, gz_d;

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, addr_match;
    logic [7:0] rd_cur, rd_nxt;

    function automatic logic [7:0] read_map(
        input logic [7:0]  a,
        input logic [7:0]  stx, sty, stz,
        input logic [15:0] t, gx, gy, gz
    );
        case (a)
            8'h0D:   read_map = stx;
            8'h0E:   read_map = sty;
            8'h0F:   read_map = stz;
            8'h41:   read_map = t[15:8];
            8'h42:   read_map = t[7:0];
            8'h43:   read_map = gx[15:8];
            8'h44:   read_map = gx[7:0];
            8'h45:   read_map = gy[15:8];
            8'h46:   read_map = gy[7:0];
            8'h47:   read_map = gz[15:8];
            8'h48:   read_map = gz[7:0];
            8'h75:   read_map = WHO_AM_I_VALUE;
            default: read_map = 8'h00;
        endcase
    endfunction

    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];
    assign scl_rise   = scl_s & ~scl_hist_q;
    assign scl_fall   = ~scl_s & scl_hist_q;
    // START/STOP only count while SCL has been high for both samples.
    assign start_det  = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det   = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    assign addr_match = (shift_q[7:1] == SLAVE_ADDRESS);
    assign rd_cur     = read_map(ptr_q, st_x_q, st_y_q, st_z_q, temp_q, gx_q, gy_q, gz_q);
    assign rd_nxt     = read_map(ptr_q + 8'd1, st_x_q, st_y_q, st_z_q, temp_q, gx_q, gy_q, gz_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            scl_sync_q  <= 2'b11;
            sda_sync_q  <= 2'b11;
            scl_hist_q  <= 1'b1;
            sda_hist_q  <= 1'b1;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            ptr_q       <= 8'h00;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            st_x_q      <= 8'h00;
            st_y_q      <= 8'h00;
            st_z_q      <= 8'h00;
            temp_q      <= 16'h0000;
            gx_q        <= 16'h0000;
            gy_q        <= 16'h0000;
            gz_q        <= 16'h0000;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_hist_q  <= scl_hist_d;
            sda_hist_q  <= sda_hist_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            st_x_q      <= st_x_d;
            st_y_q      <= st_y_d;
            st_z_q      <= st_z_d;
            temp_q      <= temp_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            gz_q        <= gz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = S_ADDR;
        end else if (stop_det) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR:      if (scl_fall && bit_cnt_q == 4'd8) state_d = addr_match ? S_ADDR_ACK : S_WAIT_STOP;
                S_ADDR_ACK:  if (scl_fall) state_d = rw_q ? S_RDATA : S_REG;
                S_REG:       if (scl_fall && bit_cnt_q == 4'd8) state_d = S_REG_ACK;
                S_REG_ACK:   if (scl_fall) state_d = S_WDATA;
                S_WDATA:     if (scl_fall && bit_cnt_q == 4'd8) state_d = S_WDATA_ACK;
                S_WDATA_ACK: if (scl_fall) state_d = S_WDATA;
                S_RDATA:     if (scl_fall && bit_cnt_q == 4'd8) state_d = S_MACK;
                // A master NACK is seen on the rising edge; still being here at the fall means ACK.
                S_MACK: begin
                    if (scl_rise && sda_s) state_d = S_WAIT_STOP;
                    else if (scl_fall)     state_d = S_RDATA;
                end
                default:     state_d = state_q;
            endcase
        end
    end

    always_comb begin
        scl_sync_d  = {scl_sync_q[0], scl};
        sda_sync_d  = {sda_sync_q[0], sda_in};
        scl_hist_d  = scl_sync_q[1];
        sda_hist_d  = sda_sync_q[1];
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        st_x_d      = st_x_q;
        st_y_d      = st_y_q;
        st_z_d      = st_z_q;
        temp_d      = temp_q;
        gx_d        = gx_q;
        gy_d        = gy_q;
        gz_d        = gz_q;

        // Freeze the snapshot during a read burst so all bytes come from one sample.
        if (sample_valid && state_q != S_RDATA && state_q != S_MACK) begin
            temp_d = temp_in;
            gx_d   = gyro_x_in;
            gy_d   = gyro_y_in;
            gz_d   = gyro_z_in;
        end

        if (start_det) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_REG, S_WDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (state_q == S_ADDR) begin
                            rw_d     = shift_q[0];
                            sda_oe_d = addr_match;
                            busy_d   = busy_q | addr_match;
                        end else if (state_q == S_REG) begin
                            ptr_d    = shift_q;
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d    = 1'b1;
                            wr_strobe_d = 1'b1;
                            ptr_d       = ptr_q + 8'd1;
                            case (ptr_q)
                                8'h0D:   st_x_d = shift_q;
                                8'h0E:   st_y_d = shift_q;
                                8'h0F:   st_z_d = shift_q;
                                default: ;
                            endcase
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            tx_d      = rd_cur;
                            sda_oe_d  = ~rd_cur[7];
                            bit_cnt_d = 4'd1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                S_REG_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                    end
                end
                // bit_cnt counts bits already placed on the bus.
                S_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d  = ~tx_q[6];
                            tx_d      = {tx_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_MACK: begin
                    if (scl_fall && state_d == S_RDATA) begin
                        ptr_d     = ptr_q + 8'd1;
                        tx_d      = rd_nxt;
                        sda_oe_d  = ~rd_nxt[7];
                        bit_cnt_d = 4'd1;
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        sda_oe      = sda_oe_q;
        busy        = busy_q;
        wr_strobe   = wr_strobe_q;
        self_test_x = st_x_q;
        self_test_y = st_y_q;
        self_test_z = st_z_q;
    end

endmodule

// File: tb/tb_i2c_mpu_target.sv
// Directed bench for i2c_mpu_target: a behavioural I2C master on an open-drain SDA net.
module tb_i2c_mpu_target;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic        sample_valid = 1'b0;
    logic [15:0] temp_in = 16'h0000;
    logic [15:0] gyro_x_in = 16'h0000;
    logic [15:0] gyro_y_in = 16'h0000;
    logic [15:0] gyro_z_in = 16'h0000;
    logic [7:0]  self_test_x, self_test_y, self_test_z;
    logic        busy, wr_strobe;

    int pass_cnt = 0;
    int total_cnt = 0;
    int wr_cnt = 0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_strobe === 1'b1) wr_cnt <= wr_cnt + 1;

    i2c_mpu_target #(.SLAVE_ADDRESS(7'h69), .WHO_AM_I_VALUE(8'h68)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
        .sample_valid(sample_valid), .temp_in(temp_in), .gyro_x_in(gyro_x_in),
        .gyro_y_in(gyro_y_in), .gyro_z_in(gyro_z_in), .self_test_x(self_test_x),
        .self_test_y(self_test_y), .self_test_z(self_test_z), .busy(busy), .wr_strobe(wr_strobe)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b0; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;  tick(Q);
        scl = 1'b1; tick(2 * Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        b = sda_line; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        ack = (sda_line == 1'b0); tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~mack);
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(5);
        rst = 1'b0; tick(2);
        total_cnt++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe got %b want 0", sda_oe); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (wr_strobe !== 1'b0) $display("FAIL reset_wr_strobe got %b want 0", wr_strobe); else pass_cnt++;
        total_cnt++; if ({self_test_x, self_test_y, self_test_z} !== 24'h0)
            $display("FAIL reset_self_test got %h want 000000", {self_test_x, self_test_y, self_test_z}); else pass_cnt++;
    endtask

    task automatic test_write_selftest();
        logic a0, a1, a2;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hD2, a0);
        write_byte(8'h0D, a1);
        write_byte(8'h03, a2);
        total_cnt++; if ({a0, a1, a2} !== 3'b111) $display("FAIL wr_acks got %b want 111", {a0, a1, a2}); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL wr_busy_mid got %b want 1", busy); else pass_cnt++;
        i2c_stop(); tick(5);
        total_cnt++; if (wr_cnt - w0 !== 1) $display("FAIL wr_strobe_count got %0d want 1", wr_cnt - w0); else pass_cnt++;
        total_cnt++; if (self_test_x !== 8'h03) $display("FAIL wr_self_test_x got %h want 03", self_test_x); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL wr_busy_after_stop got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_whoami();
        logic a0, a1, a2;
        logic [7:0] d;
        i2c_start();
        write_byte(8'hD2, a0);
        write_byte(8'h75, a1);
        i2c_start();
        write_byte(8'hD3, a2);
        total_cnt++; if ({a0, a1, a2} !== 3'b111) $display("FAIL who_acks got %b want 111", {a0, a1, a2}); else pass_cnt++;
        read_byte(d, 1'b0);
        total_cnt++; if (d !== 8'h68) $display("FAIL who_data got %h want 68", d); else pass_cnt++;
        tick(Q);
        total_cnt++; if (sda_oe !== 1'b0) $display("FAIL who_release got %b want 0", sda_oe); else pass_cnt++;
        i2c_stop(); tick(5);
    endtask

    task automatic test_burst_snapshot();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        gyro_x_in = 16'h1234; sample_valid = 1'b1; tick(1);
        sample_valid = 1'b0; tick(2);
        i2c_start();
        write_byte(8'hD2, a0);
        write_byte(8'h43, a1);
        i2c_start();
        write_byte(8'hD3, a2);
        total_cnt++; if ({a0, a1, a2} !== 3'b111) $display("FAIL burst_acks got %b want 111", {a0, a1, a2}); else pass_cnt++;
        fork
            read_byte(d0, 1'b1);
            begin
                tick(4 * Q);
                gyro_x_in = 16'hABCD; sample_valid = 1'b1; tick(1);
                sample_valid = 1'b0;
            end
        join
        read_byte(d1, 1'b0);
        i2c_stop(); tick(5);
        total_cnt++; if (d0 !== 8'h12) $display("FAIL burst_byte0 got %h want 12", d0); else pass_cnt++;
        total_cnt++; if (d1 !== 8'h34) $display("FAIL burst_byte1 got %h want 34", d1); else pass_cnt++;
    endtask

    task automatic test_wrong_address();
        logic a0, a1;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hD0, a0);
        total_cnt++; if (a0 !== 1'b0) $display("FAIL bad_addr_ack got %b want 0", a0); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL bad_addr_busy got %b want 0", busy); else pass_cnt++;
        write_byte(8'h0D, a1);
        total_cnt++; if (a1 !== 1'b0) $display("FAIL bad_addr_data_ack got %b want 0", a1); else pass_cnt++;
        i2c_stop(); tick(5);
        total_cnt++; if (wr_cnt - w0 !== 0) $display("FAIL bad_addr_strobes got %0d want 0", wr_cnt - w0); else pass_cnt++;
        total_cnt++; if (self_test_x !== 8'h03) $display("FAIL bad_addr_self_test_x got %h want 03", self_test_x); else pass_cnt++;
    endtask

    task automatic test_pointer_wrap();
        logic a0, a1, a2, a3, a4;
        logic [7:0] d;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hD2, a0);
        write_byte(8'hFF, a1);
        write_byte(8'h55, a2);
        write_byte(8'h66, a3);
        i2c_stop(); tick(5);
        total_cnt++; if ({a0, a1, a2, a3} !== 4'b1111) $display("FAIL wrap_acks got %b want 1111", {a0, a1, a2, a3}); else pass_cnt++;
        total_cnt++; if (wr_cnt - w0 !== 2) $display("FAIL wrap_strobes got %0d want 2", wr_cnt - w0); else pass_cnt++;
        total_cnt++; if ({self_test_x, self_test_y, self_test_z} !== 24'h030000)
            $display("FAIL wrap_self_test got %h want 030000", {self_test_x, self_test_y, self_test_z}); else pass_cnt++;
        i2c_start();
        write_byte(8'hD3, a4);
        read_byte(d, 1'b0);
        i2c_stop(); tick(5);
        total_cnt++; if ({a4, d} !== 9'h100) $display("FAIL wrap_read01 got ack=%b data=%h want ack=1 data=00", a4, d); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic a0, a1, a2, a3, a4, a5, a6;
        logic [7:0] d0, d1, d2;
        i2c_start();
        write_byte(8'hD2, a0);
        write_byte(8'h0E, a1);
        write_byte(8'hA5, a2);
        write_byte(8'h5A, a3);
        i2c_stop(); tick(5);
        total_cnt++; if ({self_test_y, self_test_z} !== 16'hA55A)
            $display("FAIL b2b_write got %h want a55a", {self_test_y, self_test_z}); else pass_cnt++;
        i2c_start();
        write_byte(8'hD2, a4);
        write_byte(8'h0D, a5);
        i2c_start();
        write_byte(8'hD3, a6);
        read_byte(d0, 1'b1);
        read_byte(d1, 1'b1);
        read_byte(d2, 1'b0);
        i2c_stop(); tick(5);
        total_cnt++; if ({a0, a1, a2, a3, a4, a5, a6} !== 7'h7F)
            $display("FAIL b2b_acks got %b want 1111111", {a0, a1, a2, a3, a4, a5, a6}); else pass_cnt++;
        total_cnt++; if ({d0, d1, d2} !== 24'h03A55A) $display("FAIL b2b_read got %h want 03a55a", {d0, d1, d2}); else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        logic a0, a1, a2, a3, a4, a5, b;
        i2c_start();
        write_byte(8'hD2, a0);
        write_byte(8'h0D, a1);
        i2c_start();
        write_byte(8'hD3, a2);
        for (int i = 0; i < 4; i++) read_bit(b);
        total_cnt++; if (sda_oe !== 1'b1) $display("FAIL rstmid_driving_bit3 got %b want 1", sda_oe); else pass_cnt++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (sda_oe !== 1'b0) $display("FAIL rstmid_sda_oe got %b want 0", sda_oe); else pass_cnt++;
        tick(2); rst = 1'b0; tick(2);
        total_cnt++; if ({self_test_x, self_test_y, self_test_z, busy} !== 25'h0)
            $display("FAIL rstmid_clear got st=%h busy=%b want 000000 0", {self_test_x, self_test_y, self_test_z}, busy); else pass_cnt++;
        i2c_stop(); tick(5);
        i2c_start();
        write_byte(8'hD2, a3);
        write_byte(8'h0E, a4);
        write_byte(8'h11, a5);
        i2c_stop(); tick(5);
        total_cnt++; if ({a0, a1, a2, a3, a4, a5} !== 6'h3F)
            $display("FAIL rstmid_acks got %b want 111111", {a0, a1, a2, a3, a4, a5}); else pass_cnt++;
        total_cnt++; if ({self_test_x, self_test_y} !== 16'h0011)
            $display("FAIL rstmid_new_write got %h want 0011", {self_test_x, self_test_y}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_selftest();
        test_whoami();
        test_burst_snapshot();
        test_wrong_address();
        test_pointer_wrap();
        test_back_to_back();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/i2c_mpu_target.md
Name: i2c_mpu_target

Overview:
- Synthesizable I2C target (responder) that emulates the MPU-6050 register subset our I2C master drives.
- Enables on-board loopback and bench verification of the master and register-select logic without a physical sensor.
- Sits on the same open-drain SDA/SCL net as the master. Oversamples both lines on the system clock.
- Provides register-pointer write, register write, and repeated-START register read with auto-increment.

Parameters:
- SLAVE_ADDRESS, 7'h69: 7-bit address this target answers to.
- WHO_AM_I_VALUE, 8'h68: constant returned at register 0x75.

Ports:
- clk  in  1  system clock; must be at least 8× SCL frequency.
- rst  in  1  reset.
- scl  in  1  bus clock from the master, asynchronous.
- sda_in  in  1  resolved SDA line level, asynchronous.
- sda_oe  out  1  1 = pull SDA low, 0 = release (high-Z).
- sample_valid  in  1  one-cycle strobe: new sensor sample on the *_in buses.
- temp_in  in  16  temperature sample.
- gyro_x_in  in  16  gyro X sample.
- gyro_y_in  in  16  gyro Y sample.
- gyro_z_in  in  16  gyro Z sample.
- self_test_x  out  8  register 0x0D contents.
- self_test_y  out  8  register 0x0E contents.
- self_test_z  out  8  register 0x0F contents.
- busy  out  1  high from START until STOP while addressed.
- wr_strobe  out  1  one-cycle pulse per accepted data-byte write.

Behaviour:
- Reset: rst is synchronous, active-high. It clears:
  - sda_oe, busy, wr_strobe, the self_test_* outputs, the pointer and the snapshot registers, all to 0.
  - The state to IDLE.
- Reset mid-transfer releases SDA on the next clk edge.
- Input conditioning: scl and sda_in each pass through a 2-flop synchronizer plus a 1-flop history stage. Edges are detected from the synced value and its history, so detection latency is 3 clk.
- START: SDA falls while SCL is high. It is honoured in any state (this covers repeated START): go to ADDR, clear the bit counter, release sda_oe.
- STOP: SDA rises while SCL is high. It is honoured in any state: go to IDLE, release sda_oe, drop busy.
- Bit timing:
  - Receive bits are sampled on the SCL rising edge.
  - sda_oe changes only on the SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first (7-bit address, then R/W).
    - On the 8th falling edge: if the address equals SLAVE_ADDRESS, assert sda_oe (ACK) and go to ADDR_ACK, setting busy.
    - Otherwise go to WAIT_STOP with SDA released (NACK).
  - ADDR_ACK: on the next falling edge, release sda_oe.
    - If R/W = 0, go to REG.
    - If R/W = 1, load the read byte for the current pointer, drive bit 7, and go to RDATA.
  - REG: shift 8 bits into the pointer. On the 8th falling edge, ACK and go to REG_ACK.
  - REG_ACK: release sda_oe on the next falling edge, then go to WDATA.
  - WDATA: shift 8 bits. On the 8th falling edge:
    - ACK and pulse wr_strobe.
    - If the pointer is 0x0D, 0x0E or 0x0F, write the corresponding self_test register. All other addresses are ignored, but still ACKed.
    - Increment the pointer and go to WDATA_ACK.
  - WDATA_ACK: release sda_oe on the next falling edge, then go to WDATA.
  - RDATA: sda_oe = ~current bit. Shift on each falling edge. After the 8th bit, release and go to MACK.
  - MACK: sample SDA on the rising edge.
    - Low (ACK): increment the pointer, load the next byte, and drive its MSB on the falling edge, going to RDATA.
    - High (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- Pointer: 8-bit, wraps 0xFF to 0x00. It persists across transactions and is reset only by rst.
- Read map:
  - 0x0D–0x0F: self_test_x/y/z.
  - 0x41/0x42: temp H/L.
  - 0x43–0x48: gyro X H/L, Y H/L, Z H/L, taken from the snapshot.
  - 0x75: WHO_AM_I_VALUE.
  - All other addresses: 0x00.
- Snapshot: on sample_valid, all four samples are captured into shadow registers. Capture is blocked while in RDATA or MACK, so a multi-byte burst reads one coherent sample.

Test Plan:
- Write 0x69+W, reg 0x0D, data 0x03, STOP:
  - ACK on all three bytes.
  - wr_strobe pulses once.
  - self_test_x = 0x03.
  - busy falls after STOP.
- Write 0x69+W, reg 0x75; repeated START; 0x69+R; read one byte; NACK; STOP:
  - Byte read = 0x68.
  - SDA released in WAIT_STOP.
- Set gyro_x_in = 0x1234 and pulse sample_valid; burst read from 0x43 with ACK, then NACK:
  - Bytes read = 0x12, 0x34.
  - A sample_valid of 0xABCD mid-burst does not alter the second byte.
- Address 0x68+W:
  - NACK (SDA stays high on the 9th clock).
  - No state change and no wr_strobe.
  - busy stays 0.
- Write reg 0xFF, data 0x55, 0x66:
  - Two wr_strobe pulses.
  - Pointer wraps to 0x00, then 0x01.
  - Self-test registers unchanged.
  - A following read of 0x01 returns 0x00.
- Assert rst while driving read data bit 3:
  - sda_oe = 0 the next clk.
  - self_test_* = 0.
  - A new START/address transaction is ACKed normally.
